// File: rtl/prime_checker.sv
// Sequential primality tester for 8-bit candidates over valid/ready handshakes.
// Trial division by repeated subtraction; reports smallest prime factor for composites.
module prime_checker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_num,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_num,
  output logic       out_is_prime,
  output logic [7:0] out_divisor
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_SUB   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  d_q, d_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  out_num_q, out_num_d;
  logic        out_is_prime_q, out_is_prime_d;
  logic [7:0]  out_divisor_q, out_divisor_d;
  logic [15:0] d_sq;

  // Full 16-bit square so the d*d > n test cannot wrap.
  assign d_sq = {8'd0, d_q} * {8'd0, d_q};

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    d_d            = d_q;
    rem_d          = rem_q;
    out_num_d      = out_num_q;
    out_is_prime_d = out_is_prime_q;
    out_divisor_d  = out_divisor_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          n_d = in_num;
          d_d = 8'd2;
          if (in_num < 8'd2) begin
            out_num_d      = in_num;
            out_is_prime_d = 1'b0;
            out_divisor_d  = 8'd0;
            state_d        = S_DONE;
          end else begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (d_sq > {8'd0, n_q}) begin
          out_num_d      = n_q;
          out_is_prime_d = 1'b1;
          out_divisor_d  = 8'd0;
          state_d        = S_DONE;
        end else begin
          rem_d   = n_q;
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        if (rem_q >= d_q) begin
          rem_d = rem_q - d_q;
        end else if (rem_q == 8'd0) begin
          out_num_d      = n_q;
          out_is_prime_d = 1'b0;
          out_divisor_d  = d_q;
          state_d        = S_DONE;
        end else begin
          d_d     = d_q + 8'd1;
          state_d = S_CHECK;
        end
      end
      default: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      n_q            <= 8'd0;
      d_q            <= 8'd0;
      rem_q          <= 8'd0;
      out_num_q      <= 8'd0;
      out_is_prime_q <= 1'b0;
      out_divisor_q  <= 8'd0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      d_q            <= d_d;
      rem_q          <= rem_d;
      out_num_q      <= out_num_d;
      out_is_prime_q <= out_is_prime_d;
      out_divisor_q  <= out_divisor_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign out_num      = out_num_q;
  assign out_is_prime = out_is_prime_q;
  assign out_divisor  = out_divisor_q;

endmodule
